// File: rtl/qspi_cmd_seq.sv
// Command sequencer for spi_sf: loads opcode/address/payload into the send buffer,
// runs one flash session, then drains read bytes to a byte stream.
module qspi_cmd_seq #(
    parameter int unsigned      TMO_W   = 20,
    parameter logic [TMO_W-1:0] TMO_MAX = TMO_W'(20'hFFFFF)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_opcode,
    input  logic [23:0] req_addr,
    input  logic        req_has_addr,
    input  logic        req_dummy,
    input  logic [1:0]  req_dir,
    input  logic [8:0]  req_len,
    input  logic [7:0]  wdata,
    input  logic        wdata_valid,
    output logic        wdata_ready,
    output logic [7:0]  rdata,
    output logic        rdata_valid,
    output logic        done,
    output logic        err,
    output logic        sf_start_session,
    output logic        sf_end_session,
    output logic        sf_addr,
    output logic        sf_dummy,
    output logic        sf_read_mem,
    output logic        sf_write_mem,
    output logic [8:0]  sf_nr_of_bytes,
    output logic        sf_wr,
    output logic [7:0]  sf_din,
    input  logic        sf_send_full,
    output logic        sf_rd,
    input  logic [7:0]  sf_dout,
    input  logic        sf_recv_empty,
    input  logic        sf_cycle_done
);

    localparam int unsigned LEN_W = 9;

    typedef enum logic [3:0] {
        S_IDLE, S_LD_CMD, S_LD_ADDR, S_LD_DATA, S_START,
        S_WT_BUSY, S_WT_DONE, S_DRAIN, S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       opcode_q;
    logic [23:0]      addr_q;
    logic [1:0]       addr_cnt_q, addr_cnt_d;
    logic [LEN_W-1:0] cnt_q, cnt_d, rcv_cnt_q, rcv_cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             rd_dly_q;
    logic             sf_wr_d, sf_rd_d, sf_start_d, rdata_valid_d, err_d;
    logic [7:0]       sf_din_d, rdata_d;
    logic             accept, slot_open, wr_go, rd_go, tmo_hit;

    assign accept      = (state_q == S_IDLE) && req_valid && req_ready;
    // A push slot opens only after a gap cycle and while the send buffer has room.
    assign slot_open   = !sf_wr && !sf_send_full;
    assign wr_go       = sf_write_mem && (sf_nr_of_bytes != '0);
    assign rd_go       = sf_read_mem && (sf_nr_of_bytes != '0);
    assign tmo_hit     = (tmo_q + TMO_W'(1)) == TMO_MAX;
    assign wdata_ready = (state_q == S_LD_DATA) && slot_open;

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        addr_cnt_d    = addr_cnt_q;
        cnt_d         = cnt_q;
        rcv_cnt_d     = rcv_cnt_q;
        tmo_d         = tmo_q;
        sf_wr_d       = 1'b0;
        sf_din_d      = sf_din;
        sf_rd_d       = 1'b0;
        sf_start_d    = 1'b0;
        rdata_d       = rdata;
        rdata_valid_d = 1'b0;
        err_d         = err;

        // Receive data appears on sf_dout the cycle after the sf_rd strobe.
        if (rd_dly_q) begin
            rdata_d       = sf_dout;
            rdata_valid_d = 1'b1;
            rcv_cnt_d     = rcv_cnt_q + LEN_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    err_d      = 1'b0;
                    cnt_d      = '0;
                    rcv_cnt_d  = '0;
                    addr_cnt_d = '0;
                    state_d    = S_LD_CMD;
                end
            end
            S_LD_CMD: begin
                if (slot_open) begin
                    sf_wr_d  = 1'b1;
                    sf_din_d = opcode_q;
                    if (sf_addr)    state_d = S_LD_ADDR;
                    else if (wr_go) state_d = S_LD_DATA;
                    else            state_d = S_START;
                end
            end
            S_LD_ADDR: begin
                if (slot_open) begin
                    sf_wr_d    = 1'b1;
                    addr_cnt_d = addr_cnt_q + 2'd1;
                    case (addr_cnt_q)
                        2'd0:    sf_din_d = addr_q[23:16];
                        2'd1:    sf_din_d = addr_q[15:8];
                        default: sf_din_d = addr_q[7:0];
                    endcase
                    if (addr_cnt_q == 2'd2) state_d = wr_go ? S_LD_DATA : S_START;
                end
            end
            S_LD_DATA: begin
                if (wdata_valid && wdata_ready) begin
                    sf_wr_d  = 1'b1;
                    sf_din_d = wdata;
                    cnt_d    = cnt_q + LEN_W'(1);
                    if ((cnt_q + LEN_W'(1)) == sf_nr_of_bytes) state_d = S_START;
                end
            end
            S_START: begin
                sf_start_d = 1'b1;
                tmo_d      = '0;
                cnt_d      = '0;
                state_d    = S_WT_BUSY;
            end
            S_WT_BUSY, S_WT_DONE: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else if (state_q == S_WT_BUSY) begin
                    if (!sf_cycle_done) state_d = S_WT_DONE;
                end else if (sf_cycle_done) begin
                    state_d = rd_go ? S_DRAIN : S_FIN;
                end
            end
            S_DRAIN: begin
                if (!sf_rd && (cnt_q != sf_nr_of_bytes) && !sf_recv_empty) begin
                    sf_rd_d = 1'b1;
                    cnt_d   = cnt_q + LEN_W'(1);
                end
                if (rd_dly_q && ((rcv_cnt_q + LEN_W'(1)) == sf_nr_of_bytes)) state_d = S_FIN;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; session config is held from accept until FIN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            opcode_q         <= '0;
            addr_q           <= '0;
            addr_cnt_q       <= '0;
            cnt_q            <= '0;
            rcv_cnt_q        <= '0;
            tmo_q            <= '0;
            rd_dly_q         <= 1'b0;
            req_ready        <= 1'b1;
            rdata            <= '0;
            rdata_valid      <= 1'b0;
            done             <= 1'b0;
            err              <= 1'b0;
            sf_start_session <= 1'b0;
            sf_end_session   <= 1'b0;
            sf_addr          <= 1'b0;
            sf_dummy         <= 1'b0;
            sf_read_mem      <= 1'b0;
            sf_write_mem     <= 1'b0;
            sf_nr_of_bytes   <= '0;
            sf_wr            <= 1'b0;
            sf_din           <= '0;
            sf_rd            <= 1'b0;
        end else begin
            state_q          <= state_d;
            addr_cnt_q       <= addr_cnt_d;
            cnt_q            <= cnt_d;
            rcv_cnt_q        <= rcv_cnt_d;
            tmo_q            <= tmo_d;
            rd_dly_q         <= sf_rd;
            req_ready        <= (state_d == S_IDLE);
            rdata            <= rdata_d;
            rdata_valid      <= rdata_valid_d;
            done             <= (state_d == S_FIN);
            err              <= err_d;
            sf_start_session <= sf_start_d;
            sf_wr            <= sf_wr_d;
            sf_din           <= sf_din_d;
            sf_rd            <= sf_rd_d;
            if (accept) begin
                opcode_q       <= req_opcode;
                addr_q         <= req_addr;
                sf_addr        <= req_has_addr;
                sf_dummy       <= req_dummy;
                sf_read_mem    <= (req_dir == 2'b01);
                sf_write_mem   <= (req_dir == 2'b10);
                sf_end_session <= (req_dir == 2'b00) || (req_dir == 2'b11);
                sf_nr_of_bytes <= req_len;
            end else if (state_q == S_FIN) begin
                sf_addr        <= 1'b0;
                sf_dummy       <= 1'b0;
                sf_read_mem    <= 1'b0;
                sf_write_mem   <= 1'b0;
                sf_end_session <= 1'b0;
                sf_nr_of_bytes <= '0;
            end
        end
    end

endmodule

// File: tb/tb_qspi_cmd_seq.sv
// Directed bench for qspi_cmd_seq with a small behavioural spi_sf model.
module tb_qspi_cmd_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [7:0]  req_opcode = '0;
    logic [23:0] req_addr = '0;
    logic        req_has_addr = 1'b0;
    logic        req_dummy = 1'b0;
    logic [1:0]  req_dir = '0;
    logic [8:0]  req_len = '0;
    logic [7:0]  wdata = '0;
    logic        wdata_valid = 1'b0;
    logic        wdata_ready;
    logic [7:0]  rdata;
    logic        rdata_valid, done, err;
    logic        sf_start_session, sf_end_session, sf_addr, sf_dummy;
    logic        sf_read_mem, sf_write_mem;
    logic [8:0]  sf_nr_of_bytes;
    logic        sf_wr;
    logic [7:0]  sf_din;
    logic        sf_send_full = 1'b0;
    logic        sf_rd;
    logic [7:0]  sf_dout;
    logic        sf_recv_empty;
    logic        sf_cycle_done;

    qspi_cmd_seq #(.TMO_W(20), .TMO_MAX(20'd100)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_addr(req_addr), .req_has_addr(req_has_addr), .req_dummy(req_dummy),
        .req_dir(req_dir), .req_len(req_len),
        .wdata(wdata), .wdata_valid(wdata_valid), .wdata_ready(wdata_ready),
        .rdata(rdata), .rdata_valid(rdata_valid), .done(done), .err(err),
        .sf_start_session(sf_start_session), .sf_end_session(sf_end_session),
        .sf_addr(sf_addr), .sf_dummy(sf_dummy), .sf_read_mem(sf_read_mem),
        .sf_write_mem(sf_write_mem), .sf_nr_of_bytes(sf_nr_of_bytes),
        .sf_wr(sf_wr), .sf_din(sf_din), .sf_send_full(sf_send_full),
        .sf_rd(sf_rd), .sf_dout(sf_dout), .sf_recv_empty(sf_recv_empty),
        .sf_cycle_done(sf_cycle_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // spi_sf model: session timing, receive buffer.
    logic [7:0] rx_mem [0:511];
    int   rx_len = 0;
    int   rx_rd = 0, rx_wr = 0;
    int   timer = 0;
    int   starts = 0;
    int   n_at_start = 0;
    logic hang = 1'b0;
    logic start_prev = 1'b0;
    assign sf_recv_empty = (rx_rd == rx_wr);

    // Monitor state, sampled on the falling edge.
    logic [7:0] pb  [0:63];
    logic [7:0] got [0:1023];
    int   npush = 0, ngot = 0, ndone = 0, b2b = 0, full_viol = 0;
    logic wr_prev = 1'b0;
    logic [4:0] done_cfg = '0;
    logic done_err = 1'b0;

    always @(posedge clk) begin
        start_prev <= sf_start_session;
        if (reset) begin
            sf_cycle_done <= 1'b1;
            timer         <= 0;
            rx_rd         <= 0;
            rx_wr         <= 0;
            sf_dout       <= '0;
        end else begin
            if (start_prev && !sf_start_session) begin
                sf_cycle_done <= 1'b0;
                timer         <= 5;
                n_at_start    <= npush;
                starts        <= starts + 1;
            end else if (timer > 0) begin
                timer <= timer - 1;
                if (timer == 1 && !hang) begin
                    sf_cycle_done <= 1'b1;
                    rx_rd         <= 0;
                    rx_wr         <= rx_len;
                end
            end
            if (sf_rd) begin
                sf_dout <= rx_mem[rx_rd];
                rx_rd   <= rx_rd + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (sf_wr) begin
            pb[npush % 64] = sf_din;
            npush++;
            if (wr_prev) b2b++;
            if (sf_send_full) full_viol++;
        end
        wr_prev = sf_wr;
        if (rdata_valid) begin
            got[ngot % 1024] = rdata;
            ngot++;
        end
        if (done) begin
            ndone++;
            done_cfg = {sf_end_session, sf_addr, sf_dummy, sf_read_mem, sf_write_mem};
            done_err = err;
        end
    end

    // Write payload source.
    logic [7:0] wd_all [0:63];
    int   wtaken = 0;
    int   wlimit = 0;
    always @(negedge clk) begin
        wdata_valid = (wtaken < wlimit);
        wdata       = wd_all[wtaken % 64];
    end
    always @(posedge clk) if (wdata_valid && wdata_ready) wtaken <= wtaken + 1;

    task automatic send_req(input logic [7:0] op, input logic [23:0] a, input logic ha,
                            input logic dm, input logic [1:0] d, input logic [8:0] n);
        int k = 0;
        while (!req_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("req_ready_wait", 32'(req_ready), 32'd1);
        req_opcode = op; req_addr = a; req_has_addr = ha; req_dummy = dm;
        req_dir = d; req_len = n; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget, input string tag);
        int k = 0;
        while (ndone == base && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(ndone > base), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bp, bg, bd, bs, k, fw;
        logic [7:0] pp_exp [0:7];
        logic [7:0] id_exp [0:2];

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_flags", 32'({done, err, rdata_valid, wdata_ready}), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_sf", 32'({sf_start_session, sf_end_session, sf_addr, sf_dummy, sf_read_mem,
                             sf_write_mem, sf_nr_of_bytes, sf_wr, sf_din, sf_rd}), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Read-ID
        id_exp[0] = 8'h01; id_exp[1] = 8'h20; id_exp[2] = 8'h18;
        for (int i = 0; i < 3; i++) rx_mem[i] = id_exp[i];
        rx_len = 3;
        bp = npush; bg = ngot; bd = ndone;
        send_req(8'h9F, 24'h0, 1'b0, 1'b0, 2'b01, 9'd3);
        wait_done(bd, 300, "rdid_done");
        repeat (3) @(negedge clk);
        check("rdid_npush", 32'(npush - bp), 32'd1);
        check("rdid_op", 32'(pb[bp % 64]), 32'h9F);
        check("rdid_nbytes", 32'(ngot - bg), 32'd3);
        for (int i = 0; i < 3; i++) check("rdid_byte", 32'(got[(bg + i) % 1024]), 32'(id_exp[i]));
        check("rdid_ndone", 32'(ndone - bd), 32'd1);
        check("rdid_cfg", 32'(done_cfg), 32'b00010);
        check("rdid_err", 32'(done_err), 32'd0);

        // Page program with send-full stall during address load
        pp_exp[0] = 8'h02; pp_exp[1] = 8'h12; pp_exp[2] = 8'h34; pp_exp[3] = 8'h56;
        pp_exp[4] = 8'hAA; pp_exp[5] = 8'hBB; pp_exp[6] = 8'hCC; pp_exp[7] = 8'hDD;
        for (int i = 0; i < 4; i++) wd_all[(wtaken + i) % 64] = pp_exp[4 + i];
        wlimit = wtaken + 4;
        bp = npush; bd = ndone; bs = starts;
        send_req(8'h02, 24'h123456, 1'b1, 1'b0, 2'b10, 9'd4);
        k = 0;
        while (!((npush - bp) >= 2 && !sf_wr) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("pp_full_reach", 32'(k < 100), 32'd1);
        sf_send_full = 1'b1;
        fw = 0;
        repeat (10) begin
            @(negedge clk);
            if (sf_wr) fw++;
        end
        sf_send_full = 1'b0;
        check("pp_full_nowr", 32'(fw), 32'd0);
        check("pp_full_held", 32'(npush - bp), 32'd2);
        wait_done(bd, 300, "pp_done");
        repeat (3) @(negedge clk);
        check("pp_npush", 32'(npush - bp), 32'd8);
        for (int i = 0; i < 8; i++) check("pp_din", 32'(pb[(bp + i) % 64]), 32'(pp_exp[i]));
        check("pp_start_after8", 32'(n_at_start - bp), 32'd8);
        check("pp_nstart", 32'(starts - bs), 32'd1);
        check("pp_cfg", 32'(done_cfg), 32'b01001);
        check("pp_err", 32'(done_err), 32'd0);

        // Timeout with sf_cycle_done stuck low
        hang = 1'b1;
        send_req(8'h05, 24'h0, 1'b0, 1'b0, 2'b00, 9'd0);
        k = 0;
        while (!sf_start_session && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("tmo_start_seen", 32'(sf_start_session), 32'd1);
        repeat (99) @(negedge clk);
        check("tmo_early_done", 32'(done), 32'd0);
        @(negedge clk);
        check("tmo_done", 32'(done), 32'd1);
        check("tmo_err", 32'(err), 32'd1);
        @(negedge clk);
        check("tmo_ready", 32'(req_ready), 32'd1);
        check("tmo_err_sticky", 32'(err), 32'd1);
        hang = 1'b0;

        // Reset in LD_DATA after 2 of 4 bytes
        wd_all[wtaken % 64] = 8'h11;
        wd_all[(wtaken + 1) % 64] = 8'h22;
        wlimit = wtaken + 2;
        bp = npush;
        send_req(8'h02, 24'h000400, 1'b1, 1'b0, 2'b10, 9'd4);
        check("rst_err_clear", 32'(err), 32'd0);
        k = 0;
        while ((npush - bp) < 6 && k < 100) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check("mid_npush", 32'(npush - bp), 32'd6);
        check("mid_stall_ready", 32'(wdata_ready), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("mid_sf", 32'({sf_start_session, sf_end_session, sf_addr, sf_dummy, sf_read_mem,
                             sf_write_mem, sf_nr_of_bytes, sf_wr, sf_din, sf_rd}), 32'd0);
        check("mid_ready", 32'(req_ready), 32'd1);
        check("mid_err_done", 32'({err, done}), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Fast read with dummy, maximum length
        for (int i = 0; i < 511; i++) rx_mem[i] = 8'(i) ^ 8'h5A;
        rx_len = 511;
        bp = npush; bg = ngot; bd = ndone;
        send_req(8'h6B, 24'h000100, 1'b1, 1'b1, 2'b01, 9'd511);
        wait_done(bd, 3000, "fr_done");
        repeat (3) @(negedge clk);
        check("fr_npush", 32'(npush - bp), 32'd4);
        check("fr_nbytes", 32'(ngot - bg), 32'd511);
        for (int i = 0; i < 511; i++) check("fr_byte", 32'(got[(bg + i) % 1024]), 32'(8'(i) ^ 8'h5A));
        check("fr_ndone", 32'(ndone - bd), 32'd1);
        check("fr_cfg", 32'(done_cfg), 32'b01110);
        check("fr_err", 32'(done_err), 32'd0);

        // Global slot rules
        check("wr_back_to_back", 32'(b2b), 32'd0);
        check("wr_while_full", 32'(full_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/qspi_cmd_seq.md
Name: qspi_cmd_seq

Overview:
Command sequencer that drives the quad-SPI flash engine (spi_sf) from a single request/response interface. It loads the opcode, the optional 24-bit address and any write payload into the engine's send buffer, then launches the session. It waits for the session to complete and drains read data from the receive buffer to a byte stream. It sits between the AXI register/DMA front end and spi_sf, so software no longer hand-toggles the buffer strobes and session bits.

Parameters:
TMO_W, 20, width of session timeout counter
TMO_MAX, 20'hFFFFF, cycles allowed from session start to sf_cycle_done before abort

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request offered
req_ready  out  1  sequencer accepts request (high only in IDLE)
req_opcode  in  8  flash command byte
req_addr  in  24  flash address, sent MSB byte first
req_has_addr  in  1  send 3 address bytes
req_dummy  in  1  insert dummy clocks after address
req_dir  in  2  00 none, 01 read, 10 write, 11 reserved (treated as none)
req_len  in  9  payload byte count for read/write (0 is legal only with dir=none)
wdata  in  8  write payload byte
wdata_valid  in  1  payload byte offered
wdata_ready  out  1  payload byte taken this cycle
rdata  out  8  read byte
rdata_valid  out  1  one-cycle strobe per read byte
done  out  1  one-cycle strobe at end of request
err  out  1  sticky timeout flag, cleared on next accepted request
sf_start_session  out  1  to spi_sf; session launches on its falling edge
sf_end_session  out  1  to spi_sf
sf_addr, sf_dummy, sf_read_mem, sf_write_mem  out  1 each  to spi_sf
sf_nr_of_bytes  out  9  to spi_sf
sf_wr  out  1  to spi_sf write_to_buffer_send
sf_din  out  8  to spi_sf data_input
sf_send_full  in  1  from spi_sf
sf_rd  out  1  to spi_sf read_from_buffer_receive
sf_dout  in  8  from spi_sf data_output
sf_recv_empty  in  1  from spi_sf
sf_cycle_done  in  1  from spi_sf

Behaviour:
- Reset: state IDLE; all outputs 0 except req_ready=1; rdata=0; counters 0; err=0.
- Request capture: on req_valid&req_ready, register all req_* fields. sf_addr, sf_dummy, sf_read_mem, sf_write_mem and sf_nr_of_bytes are driven from the registers and held stable until DONE. sf_end_session=1 when dir=none. Clear err.
- Byte push (two-cycle slot): sf_wr=1 for exactly 1 cycle with sf_din valid, then sf_wr=0 for at least 1 cycle. No push is issued while sf_send_full=1; the sequencer waits with sf_wr=0.
- States:
  - IDLE: wait for a request, then go to LD_CMD.
  - LD_CMD: push the opcode. Next state is LD_ADDR if has_addr, else LD_DATA if dir=write, else START.
  - LD_ADDR: push addr[23:16], addr[15:8], addr[7:0]; a 2-bit counter tracks the bytes. Then LD_DATA if dir=write, else START.
  - LD_DATA: wdata_ready=1 only in the cycle a slot opens and the buffer is not full. Each wdata_valid&wdata_ready pushes one byte. After req_len bytes, go to START. wdata_valid=0 stalls indefinitely (no timeout before START).
  - START: sf_start_session=1 for 1 cycle, then 0 (the falling edge launches the session). Load timeout counter with 0, go to WT_BUSY.
  - WT_BUSY: wait for sf_cycle_done=0, then go to WT_DONE.
  - WT_DONE: wait for sf_cycle_done=1. Then go to DRAIN if dir=read, else FIN.
  - DRAIN: while the read count < req_len and sf_recv_empty=0, pulse sf_rd for 1 cycle then 0 for 1 cycle. rdata is captured from sf_dout on the 2nd cycle after the sf_rd rise, and rdata_valid pulses for 1 cycle. After req_len bytes, go to FIN.
  - FIN: done=1 for 1 cycle, then IDLE.
- Timeout: the counter increments every cycle in WT_BUSY/WT_DONE. Reaching TMO_MAX sets err=1 and forces FIN (done still pulses). Drained bytes are not flushed.
- Counters are 9-bit and compare by equality to req_len; no wrap is possible because req_len ≤ 511.
- Reset mid-operation: all outputs return to reset values next cycle; spi_sf is reset by the same reset.
- Requests arriving while busy are ignored (req_ready=0); no queueing.

Test Plan:
- Read-ID: opcode 0x9F, has_addr=0, dir=read, len=3; sf_dout returns 0x01,0x20,0x18 → 1 sf_wr pulse with sf_din=0x9F; 3 rdata_valid strobes with 0x01,0x20,0x18; done once; err=0.
- Page program: opcode 0x02, addr 0x123456, dir=write, len=4, wdata AA,BB,CC,DD → sf_din sequence 02,12,34,56,AA,BB,CC,DD with a gap cycle between each sf_wr; the sf_start_session falling edge occurs only after the 8th push.
- Send full: hold sf_send_full=1 for 10 cycles during LD_ADDR → no sf_wr pulses during those cycles; the byte order resumes unchanged.
- Timeout: TMO_MAX=100, sf_cycle_done held at 0 → err=1 and done pulse 100 cycles after entering WT_BUSY; req_ready=1 the following cycle.
- Reset in LD_DATA after 2 of 4 bytes → next cycle all sf_* outputs are 0, req_ready=1, err=0.
- Fast-read with dummy: opcode 0x6B, dummy=1, len=511 → sf_dummy=1 throughout; exactly 511 rdata_valid strobes; done once.
